uart_tx_buffer: RTL

- Transmit-side counterpart of the UART receive path.
- On a start pulse, reads a block of bytes from a 512-entry TX buffer RAM, starting at address 0.
- Serializes each byte on the physical tx pin as 8N1, LSB first.
- Frames are sent back-to-back, with no idle bits between them.
- The core writes the buffer, pulses tx_start, and waits for tx_done.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_buffer_uart_tx.sv | 80 ++++++++
 rtl/uart_tx_buffer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and state types shared by the UART transmit path.
//   DEFAULT_CLKS_PER_BIT : clk cycles per UART bit (12 MHz / 115200 baud)
//   BUF_ADDR_W / BUF_DEPTH : TX buffer address width and depth
//   tx_ctrl_state_t : buffer fetch controller states
//   ser_state_t     : byte serializer states
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 104;
    localparam int BUF_ADDR_W           = 9;
    localparam int BUF_DEPTH            = 1 << BUF_ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RD,
        HOLD,
        DRAIN,
        DONE
    } tx_ctrl_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } ser_state_t;

endpackage

// File: rtl/uart_tx_buffer_uart_tx.sv
// uart_tx: 8N1 byte serializer, LSB first, each bit held CLKS_PER_BIT cycles.
//   clk, reset : system clock, synchronous active-high reset
//   ser_data   : byte to send, taken when ser_load is high and ser_ready is high
//   ser_load   : load request from the fetch controller
//   ser_ready  : high in S_IDLE or on the last cycle of a stop bit
//   tx         : registered serial output, idle high
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ser_data,
    input  logic       ser_load,
    output logic       ser_ready,
    output logic       tx
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

    ser_state_t    state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end   = (baud == BAUD_LAST);
    // Ready on the last stop-bit cycle lets the next start bit follow with no gap.
    assign ser_ready = (state == S_IDLE) || ((state == S_STOP) && bit_end);

    // Baud counter restarts at every bit boundary, so frames never drift.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else if (ser_load && ser_ready) begin
            state   <= S_START;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= ser_data;
            tx      <= 1'b0;
        end else if (state == S_IDLE) begin
            baud <= '0;
            tx   <= 1'b1;
        end else if (!bit_end) begin
            baud <= baud + BAUD_ONE;
        end else begin
            baud <= '0;
            case (state)
                S_START: begin
                    tx      <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_idx <= '0;
                    state   <= S_DATA;
                end
                S_DATA: begin
                    if (bit_idx == 3'd7) begin
                        tx    <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: reads a block of bytes from the TX buffer RAM (from address 0)
// and sends them back-to-back as 8N1 frames.
//   clk, reset : system clock, synchronous active-high reset
//   tx_start   : one-cycle request to send tx_len bytes (ignored while busy)
//   tx_len     : byte count 0..2^ADDR_W, larger values are clamped
//   tx_buf_rd  : RAM read data, valid the cycle after tx_buf_ren is sampled
//   tx_buf_ra  : RAM read address
//   tx_buf_ren : one-cycle read enable per byte
//   tx         : serial output, idle high
//   tx_busy    : high from accepted tx_start until tx_done
//   tx_done    : one-cycle pulse when the block is complete
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int ADDR_W       = BUF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_start,
    input  logic [ADDR_W:0]   tx_len,
    input  logic [7:0]        tx_buf_rd,
    output logic [ADDR_W-1:0] tx_buf_ra,
    output logic              tx_buf_ren,
    output logic              tx,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    tx_ctrl_state_t  state;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] fetched;
    logic [ADDR_W:0] sent;
    logic [7:0]      hold_data;
    logic            hold_valid;
    logic            rd_pending;
    logic            ser_ready;
    logic            ser_load;

    assign ser_load = hold_valid && ser_ready;

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .ser_data (hold_data),
        .ser_load (ser_load),
        .ser_ready(ser_ready),
        .tx       (tx)
    );

    // Fetch controller. HOLD captures the outstanding read on its first cycle,
    // then waits there until the holding register drains before prefetching,
    // so at most one byte is held and one is in the serializer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            len        <= '0;
            fetched    <= '0;
            sent       <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            rd_pending <= 1'b0;
            tx_buf_ra  <= '0;
            tx_buf_ren <= 1'b0;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            tx_buf_ren <= 1'b0;
            tx_done    <= 1'b0;

            if (ser_load) begin
                hold_valid <= 1'b0;
                sent       <= sent + CNT_ONE;
            end

            case (state)
                IDLE: begin
                    if (tx_start) begin
                        if (tx_len == '0) begin
                            tx_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            len     <= (tx_len > FULL_LEN) ? FULL_LEN : tx_len;
                            fetched <= '0;
                            sent    <= '0;
                            tx_busy <= 1'b1;
                            state   <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    tx_buf_ren <= 1'b1;
                    tx_buf_ra  <= fetched[ADDR_W-1:0];
                    rd_pending <= 1'b1;
                    state      <= WAIT_RD;
                end
                WAIT_RD: begin
                    state <= HOLD;
                end
                HOLD: begin
                    if (rd_pending) begin
                        hold_data  <= tx_buf_rd;
                        hold_valid <= 1'b1;
                        fetched    <= fetched + CNT_ONE;
                        rd_pending <= 1'b0;
                    end else if (fetched == len) begin
                        state <= DRAIN;
                    end else if (!hold_valid) begin
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    // ser_ready here can only be the last stop cycle of the final frame.
                    if ((sent == len) && !hold_valid && ser_ready) begin
                        tx_done   <= 1'b1;
                        tx_busy   <= 1'b0;
                        tx_buf_ra <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    tx_buf_ra <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
